// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - shared types and defaults for keypad operand entry
package operand_entry_pkg;

  localparam int DEF_NIBBLES         = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    READY   = 2'd2
  } entry_state_t;

  typedef logic [1:0] op_t;
  localparam op_t OP_PLUS = 2'b01;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchronizer, optional debounce, falling-edge pulse
// Debounce is compiled in with KEYPAD_OPERAND_DEBOUNCE_EN.
module btn_sync_edge
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_fall
);

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_vld;
  logic       r_prev;
  logic       r_armed;
  logic       w_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_vld   <= 2'b00;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
    end
  end

`ifdef KEYPAD_OPERAND_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_db;

  // Any sample agreeing with the debounced level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b1;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_db  <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_db;
`else
  assign w_level = r_sync2;
`endif

  // Arm only once the real pin has been seen released, so a press held through reset is ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_prev <= w_level;
      if (r_vld[1] && r_sync2 && w_level) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_fall = r_armed & r_prev & ~w_level;

endmodule

// File: rtl/keypad_operand_entry.sv
// rtl/keypad_operand_entry.sv - keypad digits and buttons to operands A/B and operation
// Button debounce is compiled in with KEYPAD_OPERAND_DEBOUNCE_EN.
module keypad_operand_entry
  import operand_entry_pkg::*;
#(
  parameter int NIBBLES         = DEF_NIBBLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         KEY_VALID,
  input  logic [3:0]                   KEY_CODE,
  input  logic                         BTN_ENTER_N,
  input  logic                         BTN_CLEAR_N,
  input  logic                         BTN_OP_N,
  output logic [4*NIBBLES-1:0]         A,
  output logic [4*NIBBLES-1:0]         B,
  output logic [1:0]                   Operation,
  output logic [4*NIBBLES-1:0]         EDIT_VAL,
  output logic [$clog2(NIBBLES+1)-1:0] DIGIT_CNT,
  output logic [1:0]                   SEL,
  output logic                         UPDATE
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] FULL = CW'(NIBBLES);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_edit;
  logic [CW-1:0] r_cnt;
  op_t           r_op;
  entry_state_t  r_state;
  logic          r_update;

  logic w_ev_enter;
  logic w_ev_clear;
  logic w_ev_op;
  logic w_update;

  btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .i_clk(CLK), .i_rst_n(RESET), .i_btn_n(BTN_ENTER_N), .o_fall(w_ev_enter)
  );

  btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .i_clk(CLK), .i_rst_n(RESET), .i_btn_n(BTN_CLEAR_N), .o_fall(w_ev_clear)
  );

  btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_op (
    .i_clk(CLK), .i_rst_n(RESET), .i_btn_n(BTN_OP_N), .o_fall(w_ev_op)
  );

  // Clear outranks enter, so enter only commits when clear is absent.
  always_comb begin
    w_update = w_ev_op;
    if (w_ev_clear) begin
      if (r_state == READY) w_update = 1'b1;
    end else if (w_ev_enter && (r_state != READY)) begin
      w_update = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_a      <= '0;
      r_b      <= '0;
      r_edit   <= '0;
      r_cnt    <= '0;
      r_op     <= OP_PLUS;
      r_state  <= ENTER_A;
      r_update <= 1'b0;
    end else begin
      r_update <= w_update;
      if (w_ev_op) begin
        r_op <= r_op + 2'd1;
      end
      case (r_state)
        ENTER_A, ENTER_B: begin
          if (w_ev_clear) begin
            r_edit <= '0;
            r_cnt  <= '0;
          end else if (w_ev_enter) begin
            if (r_state == ENTER_A) begin
              r_a     <= r_edit;
              r_state <= ENTER_B;
            end else begin
              r_b     <= r_edit;
              r_state <= READY;
            end
            r_edit <= '0;
            r_cnt  <= '0;
          end else if (KEY_VALID && (r_cnt < FULL)) begin
            r_edit <= {r_edit[W-5:0], KEY_CODE};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        READY: begin
          if (w_ev_clear) begin
            r_a     <= '0;
            r_b     <= '0;
            r_state <= ENTER_A;
          end else if (w_ev_enter) begin
            r_state <= ENTER_A;
          end
          r_edit <= '0;
          r_cnt  <= '0;
        end
        default: r_state <= ENTER_A;
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign Operation = r_op;
  assign EDIT_VAL  = r_edit;
  assign DIGIT_CNT = r_cnt;
  assign SEL       = r_state;
  assign UPDATE    = r_update;

endmodule
